// File: rtl/dff_pkg.sv
// Shared definitions for the elastic register pipeline.
//   occ_width(depth) : bits needed to count 0..depth valid stages
//   RESET_VAL_DEFAULT: data value loaded into every stage by async_reset
package dff_pkg;

    localparam int unsigned RESET_VAL_DEFAULT = 0;

    // Counter width able to represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_elastic_if.sv
// Valid/ready/data channel used on both sides of the elastic pipeline.
//   valid : producer has a word on data
//   ready : consumer accepts data this cycle
//   data  : WIDTH-bit payload
//   master: producer view, slave: consumer view
interface dff_pipe_elastic_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus WIDTH data bits.
//   clk, async_reset : rising-edge clock, async active-high clear to {0, RESET_VAL}
//   clr              : synchronous flush of the valid bit (data kept)
//   load             : stage may take v_in/d_in this edge
//   v_in, d_in       : incoming valid/data from the previous stage or the input
//   v_q, d_q         : stage contents
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             clr,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    logic             v_d;
    logic [WIDTH-1:0] d_d;

    // Data only moves when a real word arrives, so bubbles never toggle the data flops.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = v_in;
            if (v_in) begin
                d_d = d_in;
            end
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/dff_pipe_elastic.sv
// DEPTH-stage, WIDTH-bit elastic register pipeline with valid/ready on both sides.
//   clk, async_reset : rising-edge clock, asynchronous active-high reset
//   sync_clr         : drops all in-flight words at the next edge, blocks input this cycle
//   up (slave)       : in_valid / in_ready / in_data
//   dn (master)      : out_valid / out_ready / out_data, driven straight from the last stage
//   occupancy        : number of valid stages, present only when DFF_PIPE_OCC_EN is defined
module dff_pipe_elastic
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic                clk,
    input  logic                async_reset,
    input  logic                sync_clr,
    dff_pipe_elastic_if.slave   up,
    dff_pipe_elastic_if.master  dn
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             in_ready;

    // A stage can load if downstream accepts or any stage from here to the output is a bubble.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign rdy[i] = dn.ready | ~(&v[DEPTH-1:i]);
    end

    assign in_ready = rdy[0] & ~sync_clr;
    assign up.ready = in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;

        if (i == 0) begin : g_head
            assign v_in = up.valid;
            assign d_in = up.data;
        end else begin : g_body
            assign v_in = v[i-1];
            assign d_in = d[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk         (clk),
            .async_reset (async_reset),
            .clr         (sync_clr),
            .load        (rdy[i]),
            .v_in        (v_in),
            .d_in        (d_in),
            .v_q         (v[i]),
            .d_q         (d[i])
        );
    end

    assign dn.valid = v[DEPTH-1];
    assign dn.data  = d[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_xfer;
    logic             out_xfer;

    // Word-count tracker; flush beats any concurrent transfer.
    always_comb begin
        in_xfer  = up.valid & in_ready;
        out_xfer = v[DEPTH-1] & dn.ready;
        occ_d    = occ_q;
        if (sync_clr) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
